// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// word geometry and the latched request record.
package mem_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int LANES      = 4;
  localparam int BYTE_WIDTH = WORD_WIDTH / LANES;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_e;

  // Everything about an accepted access except its word index, whose width
  // depends on the instance's ADDR_WIDTH.
  typedef struct packed {
    logic                  we;
    logic                  oor;
    logic [LANES-1:0]      sel;
    logic [WORD_WIDTH-1:0] wdata;
  } mem_req_t;

  // True when any address bit above the word index is set.
  function automatic logic out_of_range(input logic [WORD_WIDTH-1:0] addr,
                                        input int addr_width);
    return (addr >> (addr_width + 2)) != '0;
  endfunction

endpackage

// File: rtl/data_ram_if.sv
// Data-memory port between the core (master) and the memory responder (slave).
interface data_ram_if;

  logic                                enabler;
  logic                                write_enabler;
  logic [mem_pkg::WORD_WIDTH-1:0]      addr;
  logic [mem_pkg::LANES-1:0]           select;
  logic [mem_pkg::WORD_WIDTH-1:0]      data_input;
  logic [mem_pkg::WORD_WIDTH-1:0]      data_output;
  logic                                ready;
  logic                                addr_error;

  modport master (
    output enabler, write_enabler, addr, select, data_input,
    input  data_output, ready, addr_error
  );

  modport slave (
    input  enabler, write_enabler, addr, select, data_input,
    output data_output, ready, addr_error
  );

endinterface

// File: rtl/ram_byte_array.sv
// Word-organised storage with per-byte-lane write enables and a registered
// read port sharing one address.
module ram_byte_array
  import mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [LANES-1:0]      i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  output logic [WORD_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [LANES-1:0][BYTE_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset on purpose -- contents must survive rst and
  // a reset loop over every word would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (i_we[l]) r_mem[i_addr][l] <= i_wdata[l*BYTE_WIDTH +: BYTE_WIDTH];
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/data_ram.sv
// Data-memory responder: accepts one access, holds it WAIT_CYCLES cycles,
// commits byte-lane writes or returns a full read word with a ready pulse.
module data_ram
  import mem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input logic       clk,
  input logic       rst,
  data_ram_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_e            r_state;
  mem_state_e            w_next;
  logic [CNT_W-1:0]      r_cnt;
  mem_req_t              r_req;
  logic [ADDR_WIDTH-1:0] r_word;
  logic                  r_ready;
  logic                  r_addr_error;
  logic [WORD_WIDTH-1:0] r_data_out;

  mem_req_t              w_req_in;
  mem_req_t              w_cur_req;
  logic [ADDR_WIDTH-1:0] w_cur_word;
  logic                  w_accept;
  logic                  w_commit;
  logic [LANES-1:0]      w_wr_lanes;
  logic [WORD_WIDTH-1:0] w_rd_word;

  // With WAIT_CYCLES=0 the access reaches RESP on its acceptance edge, so the
  // storage must see the live bus in IDLE and the latched copy otherwise.
  always_comb begin
    w_req_in = '{we:    bus.write_enabler,
                 oor:   out_of_range(bus.addr, ADDR_WIDTH),
                 sel:   bus.select,
                 wdata: bus.data_input};
    if (r_state == MEM_IDLE) begin
      w_cur_req  = w_req_in;
      w_cur_word = bus.addr[ADDR_WIDTH+1:2];
    end else begin
      w_cur_req  = r_req;
      w_cur_word = r_word;
    end
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MEM_IDLE: if (bus.enabler) w_next = (WAIT_CYCLES == 0) ? MEM_RESP : MEM_WAIT;
      MEM_WAIT: if (r_cnt == CNT_ONE) w_next = MEM_RESP;
      MEM_RESP: w_next = MEM_IDLE;
      default:  w_next = MEM_IDLE;
    endcase
  end

  assign w_accept   = (r_state == MEM_IDLE) && bus.enabler;
  assign w_commit   = (w_next == MEM_RESP) && (r_state != MEM_RESP) &&
                      w_cur_req.we && !w_cur_req.oor;
  assign w_wr_lanes = w_commit ? w_cur_req.sel : '0;

  ram_byte_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .i_we    (w_wr_lanes),
    .i_addr  (w_cur_word),
    .i_wdata (w_cur_req.wdata),
    .o_rdata (w_rd_word)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= MEM_IDLE;
      r_cnt        <= '0;
      r_req        <= '0;
      r_word       <= '0;
      r_ready      <= 1'b0;
      r_addr_error <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_req  <= w_req_in;
        r_word <= bus.addr[ADDR_WIDTH+1:2];
        r_cnt  <= CNT_LOAD;
      end else if (r_state == MEM_WAIT) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      r_ready      <= (r_state == MEM_RESP);
      r_addr_error <= (r_state == MEM_RESP) && r_req.oor;
      if ((r_state == MEM_RESP) && !r_req.we) begin
        r_data_out <= r_req.oor ? '0 : w_rd_word;
      end
    end
  end

  assign bus.ready       = r_ready;
  assign bus.addr_error  = r_addr_error;
  assign bus.data_output = r_data_out;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: vector table on a WAIT_CYCLES=2 instance plus
// hand sequences for zero-wait streaming, back-to-back RAW and mid-WAIT reset.
module tb_data_ram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_ram_if bus2 ();
  data_ram_if bus0 ();

  data_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );
  data_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic        err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic set_req(input int d, input logic en, input logic we,
                         input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd);
    if (d == 0) begin
      bus0.enabler = en; bus0.write_enabler = we; bus0.addr = a;
      bus0.select = s; bus0.data_input = wd;
    end else begin
      bus2.enabler = en; bus2.write_enabler = we; bus2.addr = a;
      bus2.select = s; bus2.data_input = wd;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? bus0.ready : bus2.ready;
  endfunction

  // Called at a negedge; returns at the negedge where ready is observed.
  task automatic access(input int d, input logic we, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd,
                        output int lat, output logic timed_out);
    set_req(d, 1'b1, we, a, s, wd);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    set_req(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rdy(d)) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic to;
    int   pulses;

    vecs[0]  = '{1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0040, 4'hF, 32'h0,         32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 32'h1234_5678, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         32'h00BB_00DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0024, 4'hF, 32'hCAFE_F00D, 32'h00BB_00DD, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0024, 4'h0, 32'h1111_1111, 32'h00BB_00DD, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0024, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h0102_0304, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h0102_0304, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0043, 4'hF, 32'h0,         32'h1234_5678, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h1234_5678, 1'b0};
    vecs[14] = '{1'b1, 32'h0000_0008, 4'hF, 32'h0000_FFFF, 32'h1234_5678, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         32'h0000_FFFF, 1'b0};
    vecs[16] = '{1'b0, 32'h0000_0020, 4'h1, 32'h0,         32'h00BB_00DD, 1'b0};

    set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_ready2", 0, 32'(bus2.ready), 32'h0);
    check("rst_err2",   0, 32'(bus2.addr_error), 32'h0);
    check("rst_dout2",  0, bus2.data_output, 32'h0);
    check("rst_ready0", 0, 32'(bus0.ready), 32'h0);
    check("rst_err0",   0, 32'(bus0.addr_error), 32'h0);
    check("rst_dout0",  0, bus0.data_output, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait instance: single accesses, back-to-back RAW.
    access(0, 1'b1, 32'h4, 4'hF, 32'h5A5A_5A5A, lat, to);
    check("w0_timeout", 0, 32'(to), 32'h0);
    check("w0_lat",     0, 32'(lat), 32'd2);
    access(0, 1'b1, 32'h8, 4'hF, 32'h0000_FFFF, lat, to);
    check("w0_timeout", 1, 32'(to), 32'h0);
    access(0, 1'b0, 32'h8, 4'hF, 32'h0, lat, to);
    check("w0_timeout", 2, 32'(to), 32'h0);
    check("w0_lat",     2, 32'(lat), 32'd2);
    check("w0_raw",     2, bus0.data_output, 32'h0000_FFFF);
    check("w0_err",     2, 32'(bus0.addr_error), 32'h0);

    // Zero-wait instance with a read held for 6 cycles: ready every 2 cycles.
    pulses = 0;
    set_req(0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      logic exp_rdy;
      @(posedge clk);
      @(negedge clk);
      exp_rdy = (k % 2 == 0) && (k <= 6);
      check("hold_ready", k, 32'(bus0.ready), 32'(exp_rdy));
      if (bus0.ready) begin
        pulses++;
        check("hold_err",  k, 32'(bus0.addr_error), 32'h0);
        check("hold_dout", k, bus0.data_output, 32'h5A5A_5A5A);
      end
      if (k == 6) set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    check("hold_pulses", 0, 32'(pulses), 32'd3);

    // Two-wait instance: table of back-to-back accesses.
    for (int i = 0; i < NV; i++) begin
      access(2, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, lat, to);
      check("vec_timeout", i, 32'(to), 32'h0);
      check("vec_lat",     i, 32'(lat), 32'd4);
      check("vec_err",     i, 32'(bus2.addr_error), 32'(vecs[i].err));
      check("vec_dout",    i, bus2.data_output, vecs[i].dout);
    end

    // Reset in the middle of WAIT discards a latched write.
    set_req(2, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    set_req(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", 0, 32'(bus2.ready), 32'h0);
    check("midrst_err",   0, 32'(bus2.addr_error), 32'h0);
    check("midrst_dout",  0, bus2.data_output, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus2.ready) pulses++;
    end
    check("midrst_no_ready", 0, 32'(pulses), 32'h0);
    access(2, 1'b0, 32'h10, 4'hF, 32'h0, lat, to);
    check("midrst_timeout", 1, 32'(to), 32'h0);
    check("midrst_lat",     1, 32'(lat), 32'd4);
    check("midrst_retain",  1, bus2.data_output, 32'h1122_3344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
